// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store sequencing controller.
package lsu_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 8;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // One pipeline memory request as it crosses the EX->MEM boundary
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [RD_W-1:0] rd;
    } lsu_req_t;

    localparam int unsigned REQ_W = $bits(lsu_req_t);

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication, misalign detect, load extract/extend.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_misaligned_c,
    output logic [3:0]      o_wstrb_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_ld_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half from the raw read word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Size-dependent alignment check, lane strobes, replication and extension
    always_comb begin
        o_misaligned_c = 1'b0;
        o_wstrb_c      = 4'b0000;
        o_wdata_c      = i_wdata;
        o_ld_data_c    = i_rdata;
        case (i_size)
            SZ_B: begin
                o_wstrb_c   = 4'b0001 << i_addr_lo;
                o_wdata_c   = {4{i_wdata[7:0]}};
                o_ld_data_c = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_misaligned_c = i_addr_lo[0];
                o_wstrb_c      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_c      = {2{i_wdata[15:0]}};
                o_ld_data_c    = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_W: begin
                o_misaligned_c = |i_addr_lo;
                o_wstrb_c      = 4'b1111;
            end
            SZ_R: begin
                o_misaligned_c = 1'b1;
            end
            default: begin
                o_misaligned_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one pipeline request -> one req/ack bus transaction.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = XLEN,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              data_req,
    output logic              data_wr,
    output logic [DATA_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stallreq,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic [RD_W-1:0]   ld_rd,
    output logic              excp_ale,
    output logic              excp_be
);

    // Counter value during the last cycle allowed in ADDR+DATA
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic [REQ_W-1:0]  w_req_bus;
    lsu_req_t          w_req;

    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_addr_lo;
    logic [RD_W-1:0]   r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_data_req;
    logic              r_data_wr;
    logic [DATA_W-1:0] r_data_addr;
    logic [3:0]        r_data_wstrb;
    logic [DATA_W-1:0] r_data_wdata;
    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;
    logic [RD_W-1:0]   r_ld_rd;
    logic              r_excp_be;

    logic              w_in_idle;
    logic [1:0]        w_al_size;
    logic [1:0]        w_al_addr_lo;
    logic              w_al_uns;
    logic              w_mis;
    logic [3:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata_rep;
    logic [XLEN-1:0]   w_ld_ext;

    logic              w_to;
    logic              w_accept;
    logic              w_done_ok;
    logic              w_timeout;
    logic              w_stall;

    assign w_req_bus = {req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd};
    assign w_req     = lsu_req_t'(w_req_bus);

    // Aligner sees the incoming request in IDLE and the latched one afterwards
    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_al_size    = w_in_idle ? w_req.size       : r_size;
    assign w_al_addr_lo = w_in_idle ? w_req.addr[1:0]  : r_addr_lo;
    assign w_al_uns     = w_in_idle ? w_req.uns        : r_uns;

    lsu_align u_align (
        .i_size         (w_al_size),
        .i_addr_lo      (w_al_addr_lo),
        .i_unsigned     (w_al_uns),
        .i_wdata        (w_req.wdata),
        .i_rdata        (data_rdata),
        .o_misaligned_c (w_mis),
        .o_wstrb_c      (w_wstrb),
        .o_wdata_c      (w_wdata_rep),
        .o_ld_data_c    (w_ld_ext)
    );

    assign w_to = (r_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake decode and pipeline stall
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && !w_mis) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_stall = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_to) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (data_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_stall = 1'b1;
                if (data_data_ok) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_to) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, bus outputs, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_addr_lo    <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_addr  <= '0;
            r_data_wstrb <= '0;
            r_data_wdata <= '0;
            r_ld_valid   <= 1'b0;
            r_ld_data    <= '0;
            r_ld_rd      <= '0;
            r_excp_be    <= 1'b0;
        end else begin
            r_data_req <= (w_state_nxt == ST_ADDR);
            r_ld_valid <= w_done_ok && !r_data_wr;
            r_excp_be  <= w_timeout;
            if (w_accept) begin
                r_size       <= w_req.size;
                r_uns        <= w_req.uns;
                r_addr_lo    <= w_req.addr[1:0];
                r_rd         <= w_req.rd;
                r_cnt        <= '0;
                r_data_wr    <= w_req.we;
                r_data_addr  <= {w_req.addr[XLEN-1:2], 2'b00};
                r_data_wstrb <= w_req.we ? w_wstrb : 4'b0000;
                r_data_wdata <= w_wdata_rep;
            end else if (r_state == ST_ADDR || r_state == ST_DATA) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done_ok && !r_data_wr) begin
                r_ld_data <= w_ld_ext;
                r_ld_rd   <= r_rd;
            end else if (w_timeout) begin
                r_ld_data <= '0;
            end
        end
    end

    assign data_req   = r_data_req;
    assign data_wr    = r_data_wr;
    assign data_addr  = r_data_addr;
    assign data_wstrb = r_data_wstrb;
    assign data_wdata = r_data_wdata;
    assign ld_valid   = r_ld_valid;
    assign ld_data    = r_ld_data;
    assign ld_rd      = r_ld_rd;
    assign excp_be    = r_excp_be;
    assign stallreq   = w_stall;
    assign excp_ale   = w_in_idle && req_valid && w_mis;

endmodule
